// File: rtl/ahb_bus_arbiter_if.sv
// Requester-side and AHB-side signals of the two-port bus arbiter.
// REQn rises and stays high until its one-cycle DONEn pulse. GNTn is high from grant
// through DONEn. The requester drops REQn during the DONEn cycle.
interface ahb_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              REQ0, REQ1, WRITE0, WRITE1;
  logic [ADDR_W-1:0] ADDR0, ADDR1;
  logic [DATA_W-1:0] WDATA0, WDATA1;
  logic              GNT0, GNT1, DONE0, DONE1, ERR;
  logic [DATA_W-1:0] RDATA;
  logic              HTRANS, HWRITE;
  logic [ADDR_W-1:0] HADDR;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY, HRESP;
  logic [DATA_W-1:0] HRDATA;

  modport master (
    input  REQ0, REQ1, WRITE0, WRITE1, ADDR0, ADDR1, WDATA0, WDATA1,
    input  HREADY, HRESP, HRDATA,
    output GNT0, GNT1, DONE0, DONE1, ERR, RDATA,
    output HTRANS, HWRITE, HADDR, HWDATA
  );

  modport slave (
    output REQ0, REQ1, WRITE0, WRITE1, ADDR0, ADDR1, WDATA0, WDATA1,
    output HREADY, HRESP, HRDATA,
    input  GNT0, GNT1, DONE0, DONE1, ERR, RDATA,
    input  HTRANS, HWRITE, HADDR, HWDATA
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin arbiter for two requesters sharing one AHB master port. It sequences each
// transfer as address, data and response phases, with wait-state and timeout handling.
module ahb_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  ahb_bus_arbiter_if.master bus,
  output logic [1:0]        state_dbg
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pick;

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      gnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    pick    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.REQ0 || bus.REQ1) begin
          // Under contention the requester not served last wins.
          pick    = (bus.REQ0 && bus.REQ1) ? ~last_q : bus.REQ1;
          sel_d   = pick;
          gnt_d   = pick ? 2'b10 : 2'b01;
          write_d = pick ? bus.WRITE1 : bus.WRITE0;
          addr_d  = pick ? bus.ADDR1  : bus.ADDR0;
          wdata_d = pick ? bus.WDATA1 : bus.WDATA0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        if (bus.HREADY) begin
          if (!write_q) rdata_d = bus.HRDATA;
          err_d   = bus.HRESP;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        last_d  = sel_q;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus fields are qualified by phase so that an idle bus reads as all zeros.
  assign bus.HTRANS = (state_q == ADDR);
  assign bus.HWRITE = ((state_q == ADDR) || (state_q == DATA)) && write_q;
  assign bus.HADDR  = ((state_q == ADDR) || (state_q == DATA)) ? addr_q : '0;
  assign bus.HWDATA = ((state_q == DATA) && write_q) ? wdata_q : '0;
  assign bus.GNT0   = gnt_q[0];
  assign bus.GNT1   = gnt_q[1];
  assign bus.DONE0  = (state_q == RESP) && !sel_q;
  assign bus.DONE1  = (state_q == RESP) && sel_q;
  assign bus.ERR    = err_q;
  assign bus.RDATA  = rdata_q;
  assign state_dbg  = state_q;
endmodule
